bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
- Shares one binary-to-BCD converter (20-bit in, six 4-bit digits out) between NUM_REQ requesters, e.g. IR command/address decode and the display counter.
- Round-robin arbitration; latches the winner's operand and saturates it to 999999.
- Sequences the converter with a start/done handshake, guards it with a timeout, and returns the digits to the granted requester with a one-cycle done pulse.
- Sits between the requesters and the converter, upstream of the segment display driver.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 64, WAIT cycles allowed before declaring converter failure (>= converter latency + 4).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester; held until its done/err pulse.
- req_data  in  NUM_REQ*20  operand per requester, slice i = bits [20*i+19:20*i].
- gnt  out  NUM_REQ  one-hot grant; high from grant cycle through RESP.
- done  out  NUM_REQ  one-cycle pulse to the granted requester when bcd_out is valid.
- err  out  NUM_REQ  one-cycle pulse to the granted requester on timeout.
- ovf  out  1  valid with done; operand was >999999 and was saturated.
- bcd_out  out  24  {h_hun,t_tho,tho,hun,ten,unit}; updated only in RESP, otherwise held.
- conv_start  out  1  one-cycle start pulse to the converter.
- conv_data  out  20  operand to the converter; stable from ISSUE until leaving WAIT.
- conv_busy  in  1  converter is busy; no start while high.
- conv_done  in  1  one-cycle pulse: conv_bcd is valid.
- conv_bcd  in  24  converter result.

Behaviour:
- Reset: state IDLE, rr_ptr=0, timer=0. Outputs gnt, done, err, ovf, bcd_out, conv_start and conv_data are all 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is set, pick the first set bit searching upward from rr_ptr with wrap-around. On that edge:
  - register idx and set gnt[idx];
  - set conv_data = min(req_data[idx], 999999) and ovf_q = (req_data[idx] > 999999);
  - go to ISSUE.
- ISSUE: while conv_busy=1, stay. When conv_busy=0:
  - conv_start=1 for exactly that cycle;
  - go to WAIT with timer cleared.
- WAIT: conv_done is accepted only here; a conv_done pulse in ISSUE or IDLE is ignored.
  - On conv_done: bcd_out <= conv_bcd, ovf <= ovf_q, go to RESP.
  - Otherwise the timer increments. When timer reaches TIMEOUT_CYC-1 with no conv_done: err[idx]=1 for one cycle, gnt cleared, rr_ptr = (idx+1) mod NUM_REQ, go to IDLE. bcd_out is unchanged.
  - conv_done on the same cycle the timer expires: done path wins and err is not raised.
- RESP: done[idx]=1 for exactly one cycle, with bcd_out and ovf valid.
  - Next edge: gnt cleared, rr_ptr = (idx+1) mod NUM_REQ, go to IDLE.
  - ovf returns to 0 in IDLE.
- Latency with an idle converter: req seen at cycle 0 → conv_start at cycle 1 → converter latency L → done pulse at cycle L+2.
- Requester drops req mid-transaction: the transaction still completes and the done/err pulse is still emitted; the result is simply ignored.
- No new grant is issued until the FSM is back in IDLE; minimum back-to-back spacing is one IDLE cycle.
- sys_rst asserted in any state: returns to reset values on the next edge and drops any in-flight result. A converter conv_done arriving after reset is ignored, because the FSM is not in WAIT.
- At most one bit of gnt, done and err is ever high; done and err are never high together.

Decomposition:
- Shared package bcd_pkg holds:
  - DATA_W=20, BCD_W=24, DIGITS=6, MAX_DEC=20'd999999;
  - the state encoding enum (IDLE/ISSUE/WAIT/RESP, 2 bits).
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: any and idx.
  - Reusable by the display mux.

Test Plan:
- Single request: req=01, data0=123456, converter model L=42 → conv_start at cycle 1, done[0] at cycle 44, bcd_out=24'h123456, ovf=0.
- Saturation: data1=20'hFFFFF → conv_data=999999, done[1] with bcd_out=24'h999999 and ovf=1; then data1=0 → bcd_out=24'h000000, ovf=0.
- Fairness: req=11 held continuously, data0=1, data1=2 → grants alternate 0,1,0,1; bcd_out alternates 24'h000001 / 24'h000002; rr_ptr wraps.
- Busy hold-off: conv_busy=1 for 10 cycles after grant → conv_start delayed to the first cycle with conv_busy=0, conv_data stable throughout.
- Timeout: model never asserts conv_done → err[idx] pulse exactly TIMEOUT_CYC cycles after conv_start, bcd_out unchanged, next requester served. Also drive conv_done on the expiry cycle → done, not err.
- Reset mid-WAIT: assert sys_rst for 1 cycle at cycle 20, model later pulses conv_done → no done pulse, all outputs 0, next req served normally from rr_ptr=0.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared widths, decimal limit and arbiter state encoding for
//               the shared binary-to-BCD converter arbiter and its helpers.
// Contents    : DATA_W, BCD_W, DIGITS, MAX_DEC, state_e, sat_dec()
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int DATA_W = 20;   // binary operand width
  localparam int BCD_W  = 24;   // six packed BCD digits
  localparam int DIGITS = 6;

  localparam logic [DATA_W-1:0] MAX_DEC = 20'd999999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Clamp an operand to the largest value six decimal digits can show.
  function automatic logic [DATA_W-1:0] sat_dec(input logic [DATA_W-1:0] v);
    return (v > MAX_DEC) ? MAX_DEC : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_conv_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit found searching upward from ptr_i, wrapping
//               past NUM_REQ-1 back to 0.
// Ports       : req_i  [NUM_REQ] request vector
//               ptr_i  [IDX_W]   search start position (0..NUM_REQ-1)
//               any_o            at least one request is set
//               idx_o  [IDX_W]   index of the winning request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] pos;

  // Walk the ring from the farthest offset down to offset 0 so that the
  // closest set bit to ptr_i is the last one written and therefore wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (pos >= NUM_REQ_W) begin
        pos = pos - NUM_REQ_W;
      end
      if (req_i[pos]) begin
        any_o = 1'b1;
        idx_o = pos[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_arbiter
// Description : Shares one binary-to-BCD converter between NUM_REQ
//               requesters. Round-robin grant, operand saturation to 999999,
//               start/done handshake with a timeout guard, and a one-cycle
//               done or err pulse back to the granted requester.
// Ports       : sys_clk_i, sys_rst_i         clock, sync active-high reset
//               req_i / req_data_i           requests and 20-bit operands
//               gnt_o / done_o / err_o       one-hot grant and responses
//               ovf_o, bcd_out_o             saturation flag, result digits
//               conv_start_o, conv_data_o    converter command side
//               conv_busy_i, conv_done_i,
//               conv_bcd_i                   converter status and result
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic                      ovf_o,
  output logic [BCD_W-1:0]          bcd_out_o,
  output logic                      conv_start_o,
  output logic [DATA_W-1:0]         conv_data_o,
  input  logic                      conv_busy_i,
  input  logic                      conv_done_i,
  input  logic [BCD_W-1:0]          conv_bcd_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0]    conv_data_q, conv_data_d;
  logic                 ovf_pend_q, ovf_pend_d;   // saturation seen at grant
  logic                 ovf_q, ovf_d;             // presented with done
  logic [BCD_W-1:0]     bcd_q, bcd_d;

  logic                 pick_any;
  logic [IDX_W-1:0]     pick_idx;
  logic [DATA_W-1:0]    pick_data;
  logic [IDX_W-1:0]     next_ptr;
  logic                 timer_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign pick_data = req_data_i[int'(pick_idx)*DATA_W +: DATA_W];

  // Fairness: the requester after the one just served gets first look.
  assign next_ptr = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

  // A conv_done arriving on the last allowed cycle still counts as success.
  assign timer_expired = (state_q == ST_WAIT) && !conv_done_i
                         && (timer_q == TMR_LAST);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    gnt_d       = gnt_q;
    timer_d     = timer_q;
    conv_data_d = conv_data_q;
    ovf_pend_d  = ovf_pend_q;
    ovf_d       = ovf_q;
    bcd_d       = bcd_q;

    case (state_q)
      ST_IDLE: begin
        ovf_d = 1'b0;
        if (pick_any) begin
          idx_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          conv_data_d     = sat_dec(pick_data);
          ovf_pend_d      = (pick_data > MAX_DEC);
          state_d         = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (!conv_busy_i) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (conv_done_i) begin
          bcd_d   = conv_bcd_i;
          ovf_d   = ovf_pend_q;
          state_d = ST_RESP;
        end else if (timer_expired) begin
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_RESP: begin
        gnt_d    = '0;
        rr_ptr_d = next_ptr;
        ovf_d    = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      timer_q     <= '0;
      conv_data_q <= '0;
      ovf_pend_q  <= 1'b0;
      ovf_q       <= 1'b0;
      bcd_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      timer_q     <= timer_d;
      conv_data_q <= conv_data_d;
      ovf_pend_q  <= ovf_pend_d;
      ovf_q       <= ovf_d;
      bcd_q       <= bcd_d;
    end
  end

  // Responses are decoded from the registered state; gnt_q already carries
  // the one-hot requester index, so gating it yields the one-hot pulse.
  assign gnt_o        = gnt_q;
  assign done_o       = (state_q == ST_RESP) ? gnt_q : '0;
  assign err_o        = timer_expired ? gnt_q : '0;
  assign ovf_o        = ovf_q;
  assign bcd_out_o    = bcd_q;
  assign conv_start_o = (state_q == ST_ISSUE) && !conv_busy_i;
  assign conv_data_o  = conv_data_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_conv_arbiter
// Description : Directed self-checking bench for bcd_conv_arbiter with a
//               behavioural fixed-latency converter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [39:0] req_data = '0;
  logic [1:0]  gnt, done, err;
  logic        ovf;
  logic [23:0] bcd_out;
  logic        conv_start;
  logic [19:0] conv_data;
  logic        conv_busy = 1'b0;
  logic        conv_done = 1'b0;
  logic [23:0] conv_bcd = '0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  // converter model controls
  bit          mdl_en  = 1'b1;
  int          mdl_lat = 42;
  int          mdl_cnt = 0;
  logic [19:0] mdl_data = '0;

  int t0, ts;
  bit hit, flag;

  bcd_conv_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .req_i        (req),
    .req_data_i   (req_data),
    .gnt_o        (gnt),
    .done_o       (done),
    .err_o        (err),
    .ovf_o        (ovf),
    .bcd_out_o    (bcd_out),
    .conv_start_o (conv_start),
    .conv_data_o  (conv_data),
    .conv_busy_i  (conv_busy),
    .conv_done_i  (conv_done),
    .conv_bcd_i   (conv_bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] bin2bcd(input logic [19:0] v);
    logic [23:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter: a start seen in cycle s yields conv_done during cycle s+lat.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      conv_done = 1'b0;
      if (mdl_cnt > 0) begin
        mdl_cnt = mdl_cnt - 1;
        if (mdl_cnt == 0) begin
          conv_done = 1'b1;
          conv_bcd  = bin2bcd(mdl_data);
        end
      end else if (mdl_en && conv_start) begin
        mdl_cnt  = mdl_lat;
        mdl_data = conv_data;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [19:0] v);
    req_data[20*i +: 20] = v;
  endtask

  // which: 0=done, 1=err, 2=conv_start, 3=done or err
  task automatic wait_evt(input int which, input int budget, input string tag);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && done != 0) || (which == 1 && err != 0) ||
          (which == 2 && conv_start) || (which == 3 && (done != 0 || err != 0))) begin
        hit = 1'b1;
        break;
      end
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_start", 32'(conv_start), 32'd0);
    chk("rst_cdata", 32'(conv_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- single request, L=42 ----------------
    mdl_lat = 42;
    set_data(0, 20'd123456);
    req = 2'b01;
    t0 = cyc;
    wait_evt(2, 8, "single_start_seen");
    chk("single_start_cyc", 32'(cyc - t0), 32'd1);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_cdata", 32'(conv_data), 32'd123456);
    wait_evt(0, 100, "single_done_seen");
    chk("single_done_cyc", 32'(cyc - t0), 32'd44);
    chk("single_done", 32'(done), 32'h1);
    chk("single_bcd", 32'(bcd_out), 32'h123456);
    chk("single_ovf", 32'(ovf), 32'd0);
    req = 2'b00;
    @(negedge clk);
    chk("single_done_1cyc", 32'(done), 32'd0);
    chk("single_gnt_clr", 32'(gnt), 32'd0);

    // ---------------- saturation ----------------
    mdl_lat = 5;
    set_data(1, 20'hFFFFF);
    req = 2'b10;
    wait_evt(2, 8, "sat_start_seen");
    chk("sat_cdata", 32'(conv_data), 32'd999999);
    wait_evt(0, 100, "sat_done_seen");
    chk("sat_done", 32'(done), 32'h2);
    chk("sat_bcd", 32'(bcd_out), 32'h999999);
    chk("sat_ovf", 32'(ovf), 32'd1);
    req = 2'b00;
    @(negedge clk);
    chk("sat_ovf_idle", 32'(ovf), 32'd0);
    set_data(1, 20'd0);
    req = 2'b10;
    wait_evt(0, 100, "zero_done_seen");
    chk("zero_done", 32'(done), 32'h2);
    chk("zero_bcd", 32'(bcd_out), 32'h000000);
    chk("zero_ovf", 32'(ovf), 32'd0);
    req = 2'b00;
    @(negedge clk);

    // ---------------- fairness ----------------
    mdl_lat = 3;
    set_data(0, 20'd1);
    set_data(1, 20'd2);
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_evt(0, 50, "fair_done_seen");
      chk("fair_done", 32'(done), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("fair_bcd", 32'(bcd_out), (i % 2 == 0) ? 32'h000001 : 32'h000002);
    end
    req = 2'b00;
    @(negedge clk);

    // ---------------- busy hold-off ----------------
    conv_busy = 1'b1;
    set_data(0, 20'd555);
    req = 2'b01;
    repeat (10) begin
      @(negedge clk);
      chk("busy_nostart", 32'(conv_start), 32'd0);
      chk("busy_cdata", 32'(conv_data), 32'd555);
    end
    @(posedge clk);
    #1 conv_busy = 1'b0;
    @(negedge clk);
    chk("busy_start", 32'(conv_start), 32'd1);
    chk("busy_cdata_start", 32'(conv_data), 32'd555);
    wait_evt(0, 50, "busy_done_seen");
    chk("busy_done", 32'(done), 32'h1);
    chk("busy_bcd", 32'(bcd_out), 32'h000555);
    req = 2'b00;
    @(negedge clk);

    // ---------------- timeout ----------------
    mdl_en = 1'b0;
    set_data(0, 20'd7);
    set_data(1, 20'd8);
    req = 2'b11;
    wait_evt(2, 8, "to_start_seen");
    ts = cyc;
    chk("to_gnt", 32'(gnt), 32'h2);
    wait_evt(1, 100, "to_err_seen");
    chk("to_err_cyc", 32'(cyc - ts), 32'd64);
    chk("to_err", 32'(err), 32'h2);
    chk("to_no_done", 32'(done), 32'd0);
    chk("to_bcd_held", 32'(bcd_out), 32'h000555);
    req = 2'b01;
    mdl_en = 1'b1;
    mdl_lat = 5;
    wait_evt(0, 50, "to_next_done_seen");
    chk("to_next_done", 32'(done), 32'h1);
    chk("to_next_bcd", 32'(bcd_out), 32'h000007);
    req = 2'b00;
    @(negedge clk);

    // ---------------- conv_done on expiry cycle ----------------
    mdl_lat = 64;
    set_data(0, 20'd8);
    req = 2'b01;
    wait_evt(2, 8, "exp_start_seen");
    ts = cyc;
    wait_evt(3, 100, "exp_resp_seen");
    chk("exp_no_err", 32'(err), 32'd0);
    chk("exp_done", 32'(done), 32'h1);
    chk("exp_done_cyc", 32'(cyc - ts), 32'd65);
    chk("exp_bcd", 32'(bcd_out), 32'h000008);
    req = 2'b00;
    @(negedge clk);

    // ---------------- reset mid-WAIT ----------------
    mdl_lat = 42;
    set_data(1, 20'd77);
    req = 2'b10;
    repeat (19) @(negedge clk);
    chk("rw_gnt_before", 32'(gnt), 32'h2);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done != 0 || gnt != 0 || err != 0) flag = 1'b1;
    end
    chk("rw_quiet", 32'(flag), 32'd0);
    chk("rw_bcd", 32'(bcd_out), 32'd0);
    chk("rw_cdata", 32'(conv_data), 32'd0);
    chk("rw_ovf", 32'(ovf), 32'd0);
    mdl_lat = 3;
    set_data(0, 20'd321);
    set_data(1, 20'd654);
    req = 2'b11;
    wait_evt(0, 50, "rw_next_done_seen");
    chk("rw_next_done", 32'(done), 32'h1);
    chk("rw_next_bcd", 32'(bcd_out), 32'h000321);
    req = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
